// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner: synchronises the DE0 handshake and data switches, debounces the
// handshake, emits rise/fall pulses and hands the latched byte to the core with valid/ack/overrun.
module switch_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic       fastclk,
   input  logic       nreset,
   input  logic       Bstus_raw,
   input  logic [7:0] SW_raw,
   input  logic       sw_ack,
   output logic       Bstus,
   output logic       Bstus_rise,
   output logic       Bstus_fall,
   output logic [7:0] sw_hold,
   output logic       sw_valid,
   output logic       sw_overrun
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
   typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;
   logic [SYNC_STAGES-1:0]      bs_sync_q, bs_sync_d;
   logic [SYNC_STAGES-1:0][7:0] sw_sync_q, sw_sync_d;
   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        bstus_q, bstus_d, rise_q, rise_d, fall_q, fall_d;
   logic [7:0]                  hold_q, hold_d;
   logic                        valid_q, valid_d, ovr_q, ovr_d;
   logic                        bs_s;
   logic [7:0]                  sw_s;
   assign bs_s = bs_sync_q[SYNC_STAGES-1];
   assign sw_s = sw_sync_q[SYNC_STAGES-1];
   always_comb begin
      bs_sync_d = {bs_sync_q[SYNC_STAGES-2:0], Bstus_raw};
      sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], SW_raw};
      state_d   = state_q;
      cnt_d     = cnt_q;
      bstus_d   = bstus_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      hold_d    = hold_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      case (state_q)
         LOW: begin
            if (bs_s) begin
               state_d = CHK_H;
               cnt_d   = CW'(1);
            end
         end
         CHK_H: begin
            if (!bs_s) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = HIGH;
               cnt_d   = '0;
               bstus_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HIGH: begin
            if (!bs_s) begin
               state_d = CHK_L;
               cnt_d   = CW'(1);
            end
         end
         CHK_L: begin
            if (bs_s) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = LOW;
               cnt_d   = '0;
               bstus_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
      // an ack coinciding with a rise is absorbed by the new byte, so it is not an overrun
      if (rise_d) begin
         hold_d  = sw_s;
         ovr_d   = ovr_q | (valid_q & ~sw_ack);
         valid_d = 1'b1;
      end else if (sw_ack) begin
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge fastclk or negedge nreset) begin
      if (!nreset) begin
         bs_sync_q <= '0;
         sw_sync_q <= '0;
         state_q   <= LOW;
         cnt_q     <= '0;
         bstus_q   <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         bs_sync_q <= bs_sync_d;
         sw_sync_q <= sw_sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bstus_q   <= bstus_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         hold_q    <= hold_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end
   assign Bstus      = bstus_q;
   assign Bstus_rise = rise_q;
   assign Bstus_fall = fall_q;
   assign sw_hold    = hold_q;
   assign sw_valid   = valid_q;
   assign sw_overrun = ovr_q;
endmodule

// File: tb/tb_switch_input_conditioner.sv
// tb_switch_input_conditioner: directed vector table, hand-written reset/ack corner cases and
// randomized switch activity checked against a sample-window reference model.
module tb_switch_input_conditioner;
   localparam int SYNC = 2;
   localparam int DB   = 4;
   logic       fastclk = 1'b0;
   logic       nreset, Bstus_raw, sw_ack;
   logic [7:0] SW_raw;
   logic       Bstus, Bstus_rise, Bstus_fall, sw_valid, sw_overrun;
   logic [7:0] sw_hold;
   int checks = 0;
   int errors = 0;
   switch_input_conditioner #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
      .fastclk(fastclk), .nreset(nreset), .Bstus_raw(Bstus_raw), .SW_raw(SW_raw),
      .sw_ack(sw_ack), .Bstus(Bstus), .Bstus_rise(Bstus_rise), .Bstus_fall(Bstus_fall),
      .sw_hold(sw_hold), .sw_valid(sw_valid), .sw_overrun(sw_overrun)
   );
   always #10 fastclk = ~fastclk;
   // reference: level flips when the last DB synchronised samples all disagree with it
   bit         raw_h[$];
   logic [7:0] sw_h[$];
   bit         bs_h[$];
   bit         m_lvl, m_rise, m_fall, m_valid, m_ovr, m_bs, m_acc;
   logic [7:0] m_hold, m_sws;
   always @(posedge fastclk or negedge nreset) begin
      if (!nreset) begin
         raw_h = {};
         sw_h  = {};
         bs_h  = {};
         for (int i = 0; i < SYNC; i++) begin
            raw_h.push_front(1'b0);
            sw_h.push_front(8'h00);
         end
         m_lvl = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_ovr = 0; m_hold = 8'h00;
      end else begin
         m_bs  = raw_h[SYNC-1];
         m_sws = sw_h[SYNC-1];
         raw_h.push_front(Bstus_raw);
         sw_h.push_front(SW_raw);
         void'(raw_h.pop_back());
         void'(sw_h.pop_back());
         bs_h.push_front(m_bs);
         if (bs_h.size() > DB) void'(bs_h.pop_back());
         m_acc = (bs_h.size() == DB);
         foreach (bs_h[i]) if (bs_h[i] == m_lvl) m_acc = 0;
         m_rise = m_acc && !m_lvl;
         m_fall = m_acc && m_lvl;
         if (m_acc) m_lvl = !m_lvl;
         if (m_rise) begin
            m_hold  = m_sws;
            m_ovr   = m_ovr | (m_valid & !sw_ack);
            m_valid = 1;
         end else if (sw_ack) begin
            m_valid = 0;
         end
      end
   end
   task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic check_out(input string t, input bit eb, input bit er, input bit ef,
                            input logic [7:0] eh, input bit ev, input bit eo);
      cmp({t, ".Bstus"}, Bstus, eb);
      cmp({t, ".rise"}, Bstus_rise, er);
      cmp({t, ".fall"}, Bstus_fall, ef);
      cmp({t, ".hold"}, sw_hold, eh);
      cmp({t, ".valid"}, sw_valid, ev);
      cmp({t, ".overrun"}, sw_overrun, eo);
   endtask
   task automatic run(input bit raw, input logic [7:0] sw, input bit ack, input int n);
      Bstus_raw = raw;
      SW_raw    = sw;
      sw_ack    = ack;
      repeat (n) begin
         @(posedge fastclk);
         #1;
      end
   endtask
   typedef struct {
      bit raw; logic [7:0] sw; bit ack; int n;
      bit eb, er, ef; logic [7:0] eh; bit ev, eo;
   } vec_t;
   vec_t vec[19];
   int   run_len;
   initial begin
      vec[0]  = '{1, 8'h04, 1, 1, 1, 0, 0, 8'hFF, 0, 0};
      vec[1]  = '{0, 8'h04, 0, 5, 1, 0, 0, 8'hFF, 0, 0};
      vec[2]  = '{0, 8'h04, 0, 1, 0, 0, 1, 8'hFF, 0, 0};
      vec[3]  = '{0, 8'h04, 0, 1, 0, 0, 0, 8'hFF, 0, 0};
      vec[4]  = '{1, 8'h04, 0, 5, 0, 0, 0, 8'hFF, 0, 0};
      vec[5]  = '{1, 8'h04, 0, 1, 1, 1, 0, 8'h04, 1, 0};
      vec[6]  = '{1, 8'h04, 0, 4, 1, 0, 0, 8'h04, 1, 0};
      vec[7]  = '{0, 8'h04, 0, 5, 1, 0, 0, 8'h04, 1, 0};
      vec[8]  = '{0, 8'h04, 0, 1, 0, 0, 1, 8'h04, 1, 0};
      vec[9]  = '{0, 8'h04, 0, 1, 0, 0, 0, 8'h04, 1, 0};
      vec[10] = '{1, 8'hAA, 0, 3, 0, 0, 0, 8'h04, 1, 0};
      vec[11] = '{0, 8'hAA, 0, 8, 0, 0, 0, 8'h04, 1, 0};
      vec[12] = '{0, 8'h08, 1, 1, 0, 0, 0, 8'h04, 0, 0};
      vec[13] = '{1, 8'h08, 0, 6, 1, 1, 0, 8'h08, 1, 0};
      vec[14] = '{1, 8'h08, 0, 1, 1, 0, 0, 8'h08, 1, 0};
      vec[15] = '{0, 8'h08, 0, 3, 1, 0, 0, 8'h08, 1, 0};
      vec[16] = '{1, 8'h08, 0, 6, 1, 0, 0, 8'h08, 1, 0};
      vec[17] = '{0, 8'h08, 0, 6, 0, 0, 1, 8'h08, 1, 0};
      vec[18] = '{1, 8'h08, 0, 6, 1, 1, 0, 8'h08, 1, 1};
      nreset = 0; Bstus_raw = 1; SW_raw = 8'hFF; sw_ack = 0;
      #50;
      check_out("reset", 0, 0, 0, 8'h00, 0, 0);
      #50;
      nreset = 1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge fastclk);
         #1;
         cmp($sformatf("rel_edge%0d.Bstus", i), Bstus, 1'b0);
         cmp($sformatf("rel_edge%0d.rise", i), Bstus_rise, 1'b0);
      end
      @(posedge fastclk);
      #1;
      check_out("rel_rise", 1, 1, 0, 8'hFF, 1, 0);
      for (int i = 0; i < 19; i++) begin
         run(vec[i].raw, vec[i].sw, vec[i].ack, vec[i].n);
         check_out($sformatf("vec%0d", i), vec[i].eb, vec[i].er, vec[i].ef, vec[i].eh, vec[i].ev, vec[i].eo);
      end
      run(0, 8'h08, 0, 6);
      check_out("pre_mid", 0, 0, 1, 8'h08, 1, 1);
      run(1, 8'h08, 0, 4);
      nreset = 0;
      Bstus_raw = 0;
      #1;
      check_out("mid_rst", 0, 0, 0, 8'h00, 0, 0);
      @(negedge fastclk);
      @(negedge fastclk);
      nreset = 1;
      for (int i = 0; i < 10; i++) begin
         run(0, 8'h5A, 0, 1);
         check_out($sformatf("post_rst%0d", i), 0, 0, 0, 8'h00, 0, 0);
      end
      run(1, 8'h11, 0, 6);
      check_out("sc_rise1", 1, 1, 0, 8'h11, 1, 0);
      run(0, 8'h11, 0, 6);
      check_out("sc_fall", 0, 0, 1, 8'h11, 1, 0);
      run(1, 8'h22, 0, 5);
      check_out("sc_wait", 0, 0, 0, 8'h11, 1, 0);
      run(1, 8'h22, 1, 1);
      check_out("sc_ackrise", 1, 1, 0, 8'h22, 1, 0);
      run(1, 8'h22, 0, 1);
      check_out("sc_after", 1, 0, 0, 8'h22, 1, 0);
      run(1, 8'h33, 1, 1);
      check_out("sc_ack", 1, 0, 0, 8'h22, 0, 0);
      @(negedge fastclk);
      nreset = 0; Bstus_raw = 0; sw_ack = 0;
      @(negedge fastclk);
      nreset = 1;
      run_len = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge fastclk);
         #1;
         cmp("rnd.Bstus", Bstus, m_lvl);
         cmp("rnd.rise", Bstus_rise, m_rise);
         cmp("rnd.fall", Bstus_fall, m_fall);
         cmp("rnd.hold", sw_hold, m_hold);
         cmp("rnd.valid", sw_valid, m_valid);
         cmp("rnd.overrun", sw_overrun, m_ovr);
         cmp("rnd.excl", Bstus_rise & Bstus_fall, 1'b0);
         if (run_len == 0) begin
            Bstus_raw = ~Bstus_raw;
            run_len = $urandom_range(1, 9);
         end
         run_len--;
         SW_raw = 8'($urandom);
         sw_ack = ($urandom_range(0, 5) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/switch_input_conditioner.md
Name: switch_input_conditioner

Overview:
Upstream front end for the picoMIPS core. It conditions the raw DE0 handshake switch (SW[8], Bstus) and data switches (SW[7:0]) before the core polls them. It synchronises both inputs, debounces the handshake switch with a 4-state FSM, and emits one-cycle rise/fall pulses. On each debounced rise it latches the data byte into a holding register, and a valid/ack/overrun handshake lets the core consume the byte exactly once.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth on all raw inputs; legal range 2..4.
DB_CYCLES, 4, consecutive synchronised samples required to accept a level change; legal range 2..255; counter width = $clog2(DB_CYCLES).

Ports:
fastclk  input  1  system clock (50 MHz)
nreset  input  1  asynchronous active-low reset
Bstus_raw  input  1  raw handshake switch SW[8]
SW_raw  input  8  raw data switches SW[7:0]
sw_ack  input  1  core has consumed sw_hold; one-cycle pulse
Bstus  output  1  debounced, synchronised handshake level
Bstus_rise  output  1  one-cycle pulse on accepted 0->1
Bstus_fall  output  1  one-cycle pulse on accepted 1->0
sw_hold  output  8  data byte latched on accepted rise
sw_valid  output  1  sw_hold unconsumed
sw_overrun  output  1  sticky: a rise arrived while sw_valid was still 1

Behaviour:
- One clock domain, fastclk. Reset is asynchronous and active-low (nreset); all flops are reset asynchronously.
- Reset values:
  - Synchroniser flops = 0.
  - FSM state = LOW; debounce counter = 0.
  - All outputs = 0.
  - Assertion of nreset mid-operation forces these values immediately, regardless of state.
  - If Bstus_raw is held high through reset release, a normal rise is produced after the full latency.
- Synchronisers: Bstus_raw and each SW_raw bit pass through SYNC_STAGES flops, giving bs_s and sw_s.
- FSM states:
  - LOW: Bstus=0. If bs_s=1, go to CHK_H with cnt=1; otherwise stay.
  - CHK_H: Bstus=0.
    - If bs_s=0: go to LOW, cnt=0. The glitch is rejected and no pulse is produced.
    - Else if cnt==DB_CYCLES-1: go to HIGH and register Bstus=1, Bstus_rise=1 and sw_hold<=sw_s.
    - Else: cnt++.
  - HIGH: Bstus=1. If bs_s=0, go to CHK_L with cnt=1.
  - CHK_L: mirror of CHK_H.
    - bs_s=1 returns to HIGH.
    - Completion goes to LOW, registers Bstus=0 and Bstus_fall=1, and leaves sw_hold unchanged.
- Pulses are registered and high for exactly one cycle. Bstus_rise and Bstus_fall are never high together.
- Latency: a clean raw step seen at edge 1 gives a pulse and Bstus change after edge SYNC_STAGES+DB_CYCLES (6 with defaults).
- sw_hold is captured only on accepted rises. SW_raw changes at any other time have no effect on sw_hold.
- sw_valid / sw_overrun update, evaluated on the rise edge:
  - Rise with sw_valid=0: sw_valid<=1.
  - Rise with sw_valid=1 and sw_ack=0: sw_valid stays 1, sw_overrun<=1, and sw_hold is overwritten with the new byte.
  - Rise and sw_ack in the same cycle: sw_valid stays 1, no overrun, new byte is held.
  - sw_ack without a rise: sw_valid<=0. sw_ack while sw_valid=0 is ignored.
  - sw_overrun clears only on reset.
- Counter never exceeds DB_CYCLES-1 and never wraps.
- No combinational path from any input to any output.

Test Plan:
- Reset with defaults: nreset=0 with Bstus_raw=1 and SW_raw=8'hFF -> all outputs 0. Release at t=100ns -> Bstus_rise pulses 6 cycles later and sw_hold=8'hFF, sw_valid=1.
- Clean handshake: SW_raw=8'h04, raise Bstus_raw for 10 cycles, then lower it.
  - Bstus_rise high exactly 1 cycle, 6 edges after the raise; sw_hold=8'h04; sw_valid=1.
  - Bstus_fall 6 edges after the lower; sw_hold still 8'h04.
- Glitch rejection: Bstus_raw high for 3 cycles, then low (DB_CYCLES=4) -> Bstus stays 0, no pulses, sw_hold unchanged. Repeat the glitch while in HIGH -> Bstus stays 1, no fall pulse.
- Consume/overrun, two byte sequence 8'h04 then 8'h08:
  - Pulse sw_ack after the first rise -> sw_valid=0; second rise -> sw_valid=1, sw_hold=8'h08, sw_overrun=0.
  - Repeat without sw_ack -> sw_overrun=1, sw_hold=8'h08.
- Same-cycle ack and rise: drive sw_ack in the exact cycle Bstus_rise asserts -> sw_valid=1, sw_overrun=0, new byte held.
- Mid-debounce reset: assert nreset while in CHK_H (cnt=2) -> outputs 0 immediately, no pulse. After release with Bstus_raw low, no pulses occur.
